// File: rtl/fpjh_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one fpjhSend fragmenter from NUM_CH AXIS sources.
// Locks a grant per packet, forwards beats unmodified and checks actual vs declared byte count.
module fpjh_tx_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned LEN_W  = 12,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*LEN_W-1:0] s_length,
    input  logic [NUM_CH*32-1:0]    s_axis_tdata,
    input  logic [NUM_CH*4-1:0]     s_axis_tkeep,
    input  logic [NUM_CH-1:0]       s_axis_tvalid,
    input  logic [NUM_CH-1:0]       s_axis_tlast,
    output logic [NUM_CH-1:0]       s_axis_tready,
    output logic [LEN_W-1:0]        m_length,
    output logic [CH_W-1:0]         m_ch_id,
    output logic [31:0]             m_axis_tdata,
    output logic [3:0]              m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    len_err,
    output logic                    busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StXfer} state_e;

    state_e              state_q;
    logic [CH_W-1:0]     rr_ptr_q;
    logic [CH_W-1:0]     ch_id_q;
    logic [NUM_CH-1:0]   grant_q;
    logic [LEN_W-1:0]    length_q;
    logic [LEN_W:0]      cnt_q;
    logic                len_err_q;

    logic [31:0]         data_a [NUM_CH];
    logic [3:0]          keep_a [NUM_CH];
    logic [LEN_W-1:0]    len_a  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign data_a[g] = s_axis_tdata[32*g +: 32];
        assign keep_a[g] = s_axis_tkeep[4*g +: 4];
        assign len_a[g]  = s_length[LEN_W*g +: LEN_W];
    end

    logic [NUM_CH-1:0] req;
    logic              sel_found;
    logic [CH_W-1:0]   sel_idx;

    assign req = s_axis_tvalid & ch_en;

    // First requester at or above rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        logic [CH_W:0] cand;
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!sel_found && req[cand[CH_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[CH_W-1:0];
            end
        end
    end

    logic xfer;
    assign xfer = (state_q == StXfer);

    // Data path stays combinational so beats see no added latency.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (xfer) begin
            m_axis_tdata  = data_a[ch_id_q];
            m_axis_tkeep  = keep_a[ch_id_q];
            m_axis_tvalid = s_axis_tvalid[ch_id_q];
            m_axis_tlast  = s_axis_tlast[ch_id_q];
            s_axis_tready = grant_q & {NUM_CH{m_axis_tready}};
        end
    end

    logic             hs;
    logic [2:0]       beat_bytes;
    logic [LEN_W+1:0] cnt_sum;
    logic [LEN_W:0]   cnt_next;
    logic [CH_W-1:0]  rr_next;

    assign hs         = m_axis_tvalid & m_axis_tready;
    assign beat_bytes = {2'b0, m_axis_tkeep[0]} + {2'b0, m_axis_tkeep[1]} +
                        {2'b0, m_axis_tkeep[2]} + {2'b0, m_axis_tkeep[3]};
    assign cnt_sum    = {1'b0, cnt_q} + (LEN_W+2)'(beat_bytes);
    // Saturation guarantees an overflowing packet can never match its declared length.
    assign cnt_next   = cnt_sum[LEN_W+1] ? '1 : cnt_sum[LEN_W:0];
    assign rr_next    = (ch_id_q == CH_W'(NUM_CH-1)) ? '0 : ch_id_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            ch_id_q   <= '0;
            grant_q   <= '0;
            length_q  <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        grant_q  <= NUM_CH'(1) << sel_idx;
                        ch_id_q  <= sel_idx;
                        length_q <= len_a[sel_idx];
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    cnt_q   <= '0;
                    state_q <= StXfer;
                end
                StXfer: begin
                    if (hs) begin
                        cnt_q <= cnt_next;
                        if (m_axis_tlast) begin
                            len_err_q <= (cnt_next != {1'b0, length_q});
                            rr_ptr_q  <= rr_next;
                            grant_q   <= '0;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_length = length_q;
    assign m_ch_id  = ch_id_q;
    assign len_err  = len_err_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fpjh_tx_arbiter.sv
// Randomized bench for fpjh_tx_arbiter: behavioural AXIS sources plus a packet-level
// round-robin reference model that predicts grants, forwarded beats and length errors.
module tb_fpjh_tx_arbiter;

    localparam int NCH = 4;
    localparam int LW  = 12;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_en;
    logic [NCH*LW-1:0] s_length;
    logic [NCH*32-1:0] s_axis_tdata;
    logic [NCH*4-1:0]  s_axis_tkeep;
    logic [NCH-1:0]    s_axis_tvalid;
    logic [NCH-1:0]    s_axis_tlast;
    logic [NCH-1:0]    s_axis_tready;
    logic [LW-1:0]     m_length;
    logic [CW-1:0]     m_ch_id;
    logic [31:0]       m_axis_tdata;
    logic [3:0]        m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              len_err;
    logic              busy;

    always #5 clk = ~clk;

    fpjh_tx_arbiter #(.NUM_CH(NCH), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_en         (ch_en),
        .s_length      (s_length),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_length      (m_length),
        .m_ch_id       (m_ch_id),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .len_err       (len_err),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Source state: one current packet per channel.
    int unsigned pk_beats [NCH];
    int unsigned pk_idx   [NCH];
    int unsigned pk_bytes [NCH];
    int unsigned pk_decl  [NCH];
    logic [3:0]  pk_lkeep [NCH];
    logic [31:0] cur_data [NCH];
    int          vpct;
    int          en_mode;
    int          trdy_mode;

    // Reference model: phase 0 idle, 1 grant bubble, 2 transferring.
    int             phase;
    int             m_ch;
    int             rr;
    logic           pend_err;
    logic           exp_err;
    logic [NCH-1:0] hs_v;
    int             dut_grants [NCH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic int unsigned pop4(input logic [3:0] v);
        return 32'(v[0]) + 32'(v[1]) + 32'(v[2]) + 32'(v[3]);
    endfunction

    task automatic new_packet(input int k);
        int unsigned b;
        logic [3:0]  lk;
        if ($urandom_range(0, 9) == 0) begin
            b  = 1;
            lk = 4'h0;
        end else begin
            b  = $urandom_range(1, 6);
            lk = 4'($urandom_range(1, 15));
        end
        pk_beats[k] = b;
        pk_lkeep[k] = lk;
        pk_idx[k]   = 0;
        pk_bytes[k] = 4 * (b - 1) + pop4(lk);
        pk_decl[k]  = ($urandom_range(0, 3) == 0) ? pk_bytes[k] + $urandom_range(1, 3)
                                                  : pk_bytes[k];
        cur_data[k] = $urandom;
    endtask

    function automatic logic is_last(input int k);
        return pk_idx[k] == pk_beats[k] - 1;
    endfunction

    task automatic drive_bus();
        for (int k = 0; k < NCH; k++) begin
            s_axis_tdata[32*k +: 32] = cur_data[k];
            s_axis_tkeep[4*k +: 4]   = is_last(k) ? pk_lkeep[k] : 4'hF;
            s_axis_tlast[k]          = is_last(k);
            s_length[LW*k +: LW]     = LW'(pk_decl[k]);
        end
    endtask

    task automatic update_sources(input int cyc);
        for (int k = 0; k < NCH; k++) begin
            if (hs_v[k]) begin
                if (is_last(k)) new_packet(k);
                else begin
                    pk_idx[k]++;
                    cur_data[k] = $urandom;
                end
                s_axis_tvalid[k] = ($urandom_range(1, 100) <= vpct);
            end else if (!s_axis_tvalid[k]) begin
                s_axis_tvalid[k] = ($urandom_range(1, 100) <= vpct);
            end
        end
        drive_bus();
        case (trdy_mode)
            0:       m_axis_tready = ($urandom_range(0, 9) < 7);
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b1;
        endcase
        if (en_mode == 2 && cyc % 7 == 0) ch_en = 4'($urandom_range(0, 15));
    endtask

    task automatic cycle_check();
        logic [NCH-1:0] req;
        logic [NCH-1:0] exp_rdy;
        hs_v     = '0;
        exp_err  = pend_err;
        pend_err = 1'b0;
        check_eq("len_err", 32'(len_err), 32'(exp_err));
        case (phase)
            0: begin
                check_eq("idle_busy", 32'(busy), 0);
                check_eq("idle_mvalid", 32'(m_axis_tvalid), 0);
                check_eq("idle_sready", 32'(s_axis_tready), 0);
                req = s_axis_tvalid & ch_en;
                for (int i = 0; i < NCH; i++) begin
                    int c;
                    c = (rr + i) % NCH;
                    if (phase == 0 && req[c]) begin
                        m_ch  = c;
                        phase = 1;
                    end
                end
            end
            1: begin
                check_eq("grant_busy", 32'(busy), 1);
                check_eq("grant_ch_id", 32'(m_ch_id), 32'(m_ch));
                check_eq("grant_length", 32'(m_length), pk_decl[m_ch]);
                check_eq("grant_mvalid", 32'(m_axis_tvalid), 0);
                check_eq("grant_sready", 32'(s_axis_tready), 0);
                dut_grants[m_ch_id]++;
                phase = 2;
            end
            default: begin
                check_eq("xfer_busy", 32'(busy), 1);
                check_eq("xfer_ch_id", 32'(m_ch_id), 32'(m_ch));
                check_eq("xfer_length", 32'(m_length), pk_decl[m_ch]);
                exp_rdy = m_axis_tready ? (NCH'(1) << m_ch) : '0;
                check_eq("xfer_sready", 32'(s_axis_tready), 32'(exp_rdy));
                check_eq("xfer_mvalid", 32'(m_axis_tvalid), 32'(s_axis_tvalid[m_ch]));
                if (s_axis_tvalid[m_ch]) begin
                    check_eq("xfer_data", m_axis_tdata, cur_data[m_ch]);
                    check_eq("xfer_keep", 32'(m_axis_tkeep),
                             32'(is_last(m_ch) ? pk_lkeep[m_ch] : 4'hF));
                    check_eq("xfer_last", 32'(m_axis_tlast), 32'(is_last(m_ch)));
                    if (m_axis_tready) begin
                        hs_v[m_ch] = 1'b1;
                        if (is_last(m_ch)) begin
                            pend_err = (pk_decl[m_ch] != pk_bytes[m_ch]);
                            rr       = (m_ch + 1) % NCH;
                            phase    = 0;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic model_reset();
        phase    = 0;
        rr       = 0;
        m_ch     = 0;
        pend_err = 1'b0;
        hs_v     = '0;
        for (int k = 0; k < NCH; k++) begin
            new_packet(k);
            dut_grants[k] = 0;
        end
        drive_bus();
    endtask

    // Must be entered just after a rising edge; leaves just after a rising edge.
    task automatic run_phase(input int ncyc, input int em, input int tm, input int pct);
        en_mode   = em;
        trdy_mode = tm;
        vpct      = pct;
        if (em == 0) ch_en = 4'b1111;
        else if (em == 1) ch_en = 4'b1011;
        for (int k = 0; k < NCH; k++) dut_grants[k] = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cycle_check();
            @(posedge clk);
            #1;
            update_sources(c);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sready"}, 32'(s_axis_tready), 0);
        check_eq({tag, "_mvalid"}, 32'(m_axis_tvalid), 0);
        check_eq({tag, "_mlast"}, 32'(m_axis_tlast), 0);
        check_eq({tag, "_mdata"}, m_axis_tdata, 0);
        check_eq({tag, "_mkeep"}, 32'(m_axis_tkeep), 0);
        check_eq({tag, "_length"}, 32'(m_length), 0);
        check_eq({tag, "_ch_id"}, 32'(m_ch_id), 0);
        check_eq({tag, "_len_err"}, 32'(len_err), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic found;
        int   cur;
        rst           = 1'b1;
        ch_en         = 4'b1111;
        s_axis_tvalid = 4'b1111;
        m_axis_tready = 1'b1;
        en_mode       = 0;
        trdy_mode     = 2;
        vpct          = 100;
        model_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // All channels requesting back to back: strict rotation, nobody starved.
        run_phase(400, 0, 2, 100);
        for (int k = 0; k < NCH; k++) check_eq("no_starve", 32'(dut_grants[k] > 0), 1);

        // Channel 2 masked, ready toggling every cycle.
        run_phase(300, 1, 1, 100);
        check_eq("ch2_never_granted", 32'(dut_grants[2]), 0);

        // Enables changing under live traffic with random stalls on both sides.
        run_phase(500, 2, 0, 60);

        // Asynchronous reset asserted while a packet is in flight.
        ch_en = 4'b1111;
        en_mode = 0;
        vpct  = 80;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            cur = phase;
            cycle_check();
            if (cur == 2) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
                update_sources(c);
            end
        end
        check_eq("reset_mid_packet_reached", 32'(found), 1);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        s_axis_tvalid = 4'b1110;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        run_phase(300, 0, 0, 80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpjh_tx_arbiter.md
Name: fpjh_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one fpjhSend fragmenter among NUM_CH upstream 32-bit AXIS sources.
- Locks a grant per packet and forwards that channel's beats unmodified.
- Presents the winner's byte length on m_length, held stable for the whole packet, plus the channel id.
- Sits directly upstream of fpjhSend; checks each packet's actual byte count against its declared length.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
LEN_W, 12, width of per-packet byte length
CH_W, $clog2(NUM_CH), channel id width (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
ch_en  in  NUM_CH  per-channel enable; disabled channels are never granted
s_length  in  NUM_CH*LEN_W  declared byte length per channel, valid while that channel's tvalid is high
s_axis_tdata  in  NUM_CH*32  channel data, channel k at [32k+31:32k]
s_axis_tkeep  in  NUM_CH*4  channel byte enables
s_axis_tvalid  in  NUM_CH  channel valid
s_axis_tlast  in  NUM_CH  channel last
s_axis_tready  out  NUM_CH  channel ready, one-hot or zero
m_length  out  LEN_W  latched length to fpjhSend i_length
m_ch_id  out  CH_W  id of the granted channel
m_axis_tdata  out  32  to fpjhSend
m_axis_tkeep  out  4  to fpjhSend
m_axis_tvalid  out  1  to fpjhSend
m_axis_tlast  out  1  to fpjhSend
m_axis_tready  in  1  from fpjhSend
len_err  out  1  one-cycle pulse on declared/actual length mismatch
busy  out  1  high while in GRANT or XFER

Behaviour:
- Reset (rst=0, async):
  - State IDLE; rr_ptr=0; grant=0.
  - m_length=0, m_ch_id=0; s_axis_tready all 0.
  - m_axis_tvalid/tlast=0, m_axis_tdata/tkeep=0.
  - len_err=0, busy=0; byte counter=0.
- Requests: req[k] = s_axis_tvalid[k] & ch_en[k].
- IDLE:
  - If any req, select the first requesting k searching upward from rr_ptr, wrapping modulo NUM_CH.
  - Register grant=onehot(k), m_ch_id=k, m_length=s_length[k]; go to GRANT. Selection takes 1 cycle.
- GRANT: one cycle; byte counter cleared; go to XFER. Costs one bubble per packet, allowed by fpjhSend input gaps.
- XFER (combinational mux on the granted channel):
  - m_axis_t* = channel k's t*.
  - s_axis_tready[k] = m_axis_tready; other channels' tready = 0.
  - Each handshake (m_axis_tvalid & m_axis_tready): byte counter += popcount(tkeep).
  - On the tlast handshake:
    - Compare (counter + popcount) with m_length; if unequal, len_err=1 on the next cycle only.
    - rr_ptr = (k+1) mod NUM_CH; grant cleared; go to IDLE.
- Packet-boundary guarantee: a packet is never interrupted.
  - ch_en[k] deasserting mid-packet has no effect until that packet's tlast.
  - A tvalid drop mid-packet just stalls the output (m_axis_tvalid=0); grant is held.
- m_length and m_ch_id are stable from GRANT until the next grant.
- Out-of-range data:
  - Byte counter is LEN_W+1 bits wide and saturates at all-ones; overflow reports len_err.
  - Length 0 declared with a one-beat tkeep=0 packet is legal and produces no error.
- Minimum packet cadence: 1 IDLE + 1 GRANT + N beats.
- No latency is added to data beats; outputs are combinational from the granted inputs.

Test Plan:
- Single channel 0: 15 beats, tkeep=F…F then 8 on last, s_length=57 -> m_length=57, m_ch_id=0; 15 beats forwarded identically (data 0x12345678 incrementing); len_err never asserts.
- All 4 channels request continuously, 15-beat packets -> grant order 0,1,2,3,0…; exactly 2 cycles with m_axis_tvalid=0 between each tlast handshake and the next first beat; no channel is starved.
- m_axis_tready toggling 1/0 every cycle during a packet -> beat count and data order are preserved; the non-granted s_axis_tready stays 0 throughout.
- Channel 1 declares s_length=60 but sends 57 bytes -> len_err is a 1-cycle pulse after tlast; the next packet proceeds normally.
- ch_en=4'b1011 with all channels requesting -> channel 2 is never granted; clearing ch_en[0] mid-packet lets channel 0 finish its packet before the grant moves to 1.
- rst driven low mid-packet (async) -> all outputs reach their reset values immediately; after release the first grant goes to the lowest enabled requester starting from 0.
